// File: rtl/video_timing_pipe.sv
// video_timing_pipe
//   RGB-panel timing generator with line-buffer address generation and
//   read-latency compensation. Single clk_pixel domain.
//
//   Optional macro VIDEO_TEST_PATTERN_EN adds a test_mode input that replaces
//   pix_in with an internal 8-bar colour pattern.
//
// Ports:
//   clk_pixel, rst_n (async, active low)
//   enable        run request; start/stop only takes effect on frame boundary
//   test_mode     (VIDEO_TEST_PATTERN_EN only) select internal colour bars
//   pix_in[23:0]  RGB888 from line buffer, PIPE_DELAY cycles after rd_addr
//   rd_addr       line-buffer read address (combinational from counters)
//   line_idx      visible line to fetch, valid with line_req
//   line_req      one-cycle prefetch pulse, PREFETCH pixels before line end
//   frame_start   one-cycle pulse at counter (0,0) while running
//   busy          state != IDLE
//   LCD_*         panel pins, all aligned PIPE_DELAY+1 cycles after counters
module video_timing_pipe #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 48,
  parameter int H_BP       = 40,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 13,
  parameter int V_SYNC     = 1,
  parameter int V_BP       = 31,
  parameter int HS_POL     = 1,
  parameter int VS_POL     = 1,
  parameter int PIPE_DELAY = 1,
  parameter int PREFETCH   = 16
) (
  input  logic                        clk_pixel,
  input  logic                        rst_n,
  input  logic                        enable,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic                        test_mode,
`endif
  input  logic [23:0]                 pix_in,
  output logic [$clog2(H_ACTIVE)-1:0] rd_addr,
  output logic [$clog2(V_ACTIVE)-1:0] line_idx,
  output logic                        line_req,
  output logic                        frame_start,
  output logic                        busy,
  output logic                        LCD_HSYNC,
  output logic                        LCD_VSYNC,
  output logic                        LCD_DEN,
  output logic [4:0]                  LCD_R,
  output logic [5:0]                  LCD_G,
  output logic [4:0]                  LCD_B
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  // One spare bit so region end bounds equal to the total still fit.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int AW = $clog2(H_ACTIVE);
  localparam int LW = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_S  = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_ACT_E  = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [HW-1:0] H_REQ    = HW'(H_TOTAL - PREFETCH);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_S  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_E  = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic          HS_ACT   = (HS_POL != 0);
  localparam logic          VS_ACT   = (VS_POL != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e                     state_q, state_d;
  logic [HW-1:0]              h_q, h_d;
  logic [VW-1:0]              v_q, v_d;
  logic [LW-1:0]              line_idx_q, line_idx_d;
  // Timing shift register, bits {hs, vs, de}; stage k holds raw timing from
  // k+1 cycles ago, so stage PIPE_DELAY drives the pins.
  logic [PIPE_DELAY:0][2:0]   tim_pipe_q, tim_pipe_d;
  logic [15:0]                rgb_q, rgb_d;

  logic          running, h_last, v_last, hs_raw, vs_raw, de_raw, next_vis;
  logic [VW-1:0] v_nxt;
  logic [23:0]   pix_src;
  logic          unused_pix;

`ifdef VIDEO_TEST_PATTERN_EN
  // Pattern pixel is delayed like a line-buffer read so it lines up with
  // the same de stage that gates pix_in.
  logic [PIPE_DELAY-1:0][23:0] pat_pipe_q, pat_pipe_d;
  logic [2:0]                  bar;
  logic [23:0]                 bar_rgb;

  always_comb begin
    bar = 3'((32'(rd_addr) * 8) / H_ACTIVE);
    case (bar)
      3'd0:    bar_rgb = 24'hFFFFFF;  // white
      3'd1:    bar_rgb = 24'hFFFF00;  // yellow
      3'd2:    bar_rgb = 24'h00FFFF;  // cyan
      3'd3:    bar_rgb = 24'h00FF00;  // green
      3'd4:    bar_rgb = 24'hFF00FF;  // magenta
      3'd5:    bar_rgb = 24'hFF0000;  // red
      3'd6:    bar_rgb = 24'h0000FF;  // blue
      default: bar_rgb = 24'h000000;  // black
    endcase
    pat_pipe_d    = pat_pipe_q;
    pat_pipe_d[0] = bar_rgb;
    for (int k = 1; k < PIPE_DELAY; k++) pat_pipe_d[k] = pat_pipe_q[k-1];
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) pat_pipe_q <= '0;
    else        pat_pipe_q <= pat_pipe_d;
  end

  assign pix_src = test_mode ? pat_pipe_q[PIPE_DELAY-1] : pix_in;
`else
  assign pix_src = pix_in;
`endif

  // Low bits of each colour channel are dropped by the 565 panel.
  assign unused_pix = ^{pix_src[18:16], pix_src[9:8], pix_src[2:0]};

  always_comb begin
    running  = (state_q != ST_IDLE);
    h_last   = (h_q == H_LAST);
    v_last   = (v_q == V_LAST);
    v_nxt    = v_last ? '0 : v_q + VW'(1);
    next_vis = (v_nxt >= V_ACT_S) && (v_nxt < V_ACT_E);

    hs_raw = running && (h_q < H_SYNC_E);
    vs_raw = running && (v_q < V_SYNC_E);
    de_raw = running && (h_q >= H_ACT_S) && (h_q < H_ACT_E)
                     && (v_q >= V_ACT_S) && (v_q < V_ACT_E);

    rd_addr     = de_raw ? AW'(h_q - H_ACT_S) : '0;
    frame_start = running && (h_q == '0) && (v_q == '0);
    busy        = running;

    // line_idx is shown in the same cycle as its line_req, then held.
    line_req   = running && (h_q == H_REQ) && next_vis;
    line_idx_d = line_req ? LW'(v_nxt - V_ACT_S) : line_idx_q;
    line_idx   = line_idx_d;

    // Start/stop: DRAIN finishes the current frame unless enable returns.
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable)                state_d = ST_RUN;
        else if (h_last && v_last) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    // Counters only advance once running; leaving DRAIN at (last,last)
    // wraps them back to 0 naturally.
    h_d = h_q;
    v_d = v_q;
    if (running) begin
      h_d = h_last ? '0 : h_q + HW'(1);
      if (h_last) v_d = v_nxt;
    end

    tim_pipe_d    = tim_pipe_q;
    tim_pipe_d[0] = {hs_raw, vs_raw, de_raw};
    for (int k = 1; k <= PIPE_DELAY; k++) tim_pipe_d[k] = tim_pipe_q[k-1];

    // Capture in the cycle pix_in answers the address issued PIPE_DELAY ago.
    rgb_d = tim_pipe_q[PIPE_DELAY-1][0]
          ? {pix_src[23:19], pix_src[15:10], pix_src[7:3]} : '0;

    LCD_HSYNC = ~(tim_pipe_q[PIPE_DELAY][2] ^ HS_ACT);
    LCD_VSYNC = ~(tim_pipe_q[PIPE_DELAY][1] ^ VS_ACT);
    LCD_DEN   = tim_pipe_q[PIPE_DELAY][0];
    LCD_R     = rgb_q[15:11];
    LCD_G     = rgb_q[10:5];
    LCD_B     = rgb_q[4:0];
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      h_q        <= '0;
      v_q        <= '0;
      line_idx_q <= '0;
      tim_pipe_q <= '0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      line_idx_q <= line_idx_d;
      tim_pipe_q <= tim_pipe_d;
      rgb_q      <= rgb_d;
    end
  end

endmodule

// File: tb/tb_video_timing_pipe.sv
// Bench for video_timing_pipe on a small timing set. A behavioural model of
// the counters/FSM gives per-cycle expectations; pin values are queued when
// the counter cycle is stepped and popped PIPE_DELAY+1 cycles later.
// A second instance with inverted sync polarity shares the stimulus.
module tb_video_timing_pipe;
  localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
  localparam int V_ACTIVE = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
  localparam int PD = 2, PF = 3;
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;  // 14
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;  // 7

  logic        clk_pixel = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        test_mode = 1'b0;
  logic [23:0] pix_in;
  logic [2:0]  rd_addr, n_rd_addr;
  logic [1:0]  line_idx, n_line_idx;
  logic        line_req, frame_start, busy, hs_p, vs_p, den;
  logic        n_line_req, n_frame_start, n_busy, n_hs, n_vs, n_den;
  logic [4:0]  lr, lb, n_r, n_b;
  logic [5:0]  lg, n_g;

  always #5 clk_pixel = ~clk_pixel;

  video_timing_pipe #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1), .VS_POL(1), .PIPE_DELAY(PD), .PREFETCH(PF)
  ) dut (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable),
`ifdef VIDEO_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .pix_in(pix_in), .rd_addr(rd_addr), .line_idx(line_idx),
    .line_req(line_req), .frame_start(frame_start), .busy(busy),
    .LCD_HSYNC(hs_p), .LCD_VSYNC(vs_p), .LCD_DEN(den),
    .LCD_R(lr), .LCD_G(lg), .LCD_B(lb)
  );

  video_timing_pipe #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(0), .VS_POL(0), .PIPE_DELAY(PD), .PREFETCH(PF)
  ) dut_n (
    .clk_pixel(clk_pixel), .rst_n(rst_n), .enable(enable),
`ifdef VIDEO_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .pix_in(pix_in), .rd_addr(n_rd_addr), .line_idx(n_line_idx),
    .line_req(n_line_req), .frame_start(n_frame_start), .busy(n_busy),
    .LCD_HSYNC(n_hs), .LCD_VSYNC(n_vs), .LCD_DEN(n_den),
    .LCD_R(n_r), .LCD_G(n_g), .LCD_B(n_b)
  );

  // Line-buffer model: data answers rd_addr PD cycles later.
  function automatic logic [23:0] ramp(input logic [2:0] a);
    ramp = {8'(32'(a) * 37 + 5), 8'(32'(a) * 11 + 100), {a, 5'b0}};
  endfunction

  function automatic logic [15:0] to565(input logic [23:0] p);
    to565 = {p[23:19], p[15:10], p[7:3]};
  endfunction

  logic [2:0] a1 = '0, a2 = '0;
  always @(posedge clk_pixel) begin
    a1 <= rd_addr;
    a2 <= a1;
  end
  assign pix_in = ramp(a2);

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [15:0] rgb;
  } pin_t;

  pin_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   m_state, mh, mv, m_lidx;
  logic win = 1'b0;
  int   den_cnt = 0, hs_cnt = 0, vs_cnt = 0;
  logic first_wait = 1'b0, first_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; mh = 0; mv = 0; m_lidx = 0;
    exp_q.delete();
    repeat (PD + 1) exp_q.push_back('0);
  endtask

  function automatic logic m_de();
    m_de = (m_state != 0) && (mh >= H_SYNC + H_BP) && (mh < H_SYNC + H_BP + H_ACTIVE)
        && (mv >= V_SYNC + V_BP) && (mv < V_SYNC + V_BP + V_ACTIVE);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
    chk({tag, "_line_idx"}, 32'(line_idx), 0);
    chk({tag, "_line_req"}, 32'(line_req), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_den"}, 32'(den), 0);
    chk({tag, "_rgb"}, {16'h0, lr, lg, lb}, 0);
    chk({tag, "_hsync"}, 32'(hs_p), 0);
    chk({tag, "_vsync"}, 32'(vs_p), 0);
    chk({tag, "_hsync_n"}, 32'(n_hs), 1);
    chk({tag, "_vsync_n"}, 32'(n_vs), 1);
  endtask

  // One counter cycle: check at negedge, drive enable, advance the model.
  task automatic cyc(input logic en);
    logic ehs, evs, ede, efs, elr, run;
    int   eaddr, nv, old;
    pin_t e, o;
    run   = (m_state != 0);
    ehs   = run && (mh < H_SYNC);
    evs   = run && (mv < V_SYNC);
    ede   = m_de();
    eaddr = ede ? mh - (H_SYNC + H_BP) : 0;
    efs   = run && (mh == 0) && (mv == 0);
    nv    = (mv + 1) % V_TOTAL;
    elr   = run && (mh == H_TOTAL - PF) && (nv >= V_SYNC + V_BP) && (nv < V_SYNC + V_BP + V_ACTIVE);
    if (elr) m_lidx = nv - (V_SYNC + V_BP);

    chk("rd_addr", 32'(rd_addr), eaddr);
    chk("frame_start", 32'(frame_start), 32'(efs));
    chk("line_req", 32'(line_req), 32'(elr));
    chk("line_idx", 32'(line_idx), m_lidx);
    chk("busy", 32'(busy), 32'(run));

    e.hs = ehs; e.vs = evs; e.de = ede;
    e.rgb = ede ? to565(ramp(3'(eaddr))) : '0;
    exp_q.push_back(e);
    if (exp_q.size() > PD + 1) begin
      o = exp_q.pop_front();
      chk("hsync", 32'(hs_p), 32'(o.hs));
      chk("vsync", 32'(vs_p), 32'(o.vs));
      chk("den", 32'(den), 32'(o.de));
      chk("rgb", {16'h0, lr, lg, lb}, {16'h0, o.rgb});
      chk("hsync_n", 32'(n_hs), 32'(!o.hs));
      chk("vsync_n", 32'(n_vs), 32'(!o.vs));
    end

    if (win) begin
      den_cnt += int'(den);
      hs_cnt  += int'(hs_p);
      vs_cnt  += int'(vs_p);
    end
    if (first_wait && (frame_start || line_req)) begin
      chk("first_pulse", 32'(frame_start), 1);
      first_wait = 1'b0;
      first_seen = 1'b1;
    end

    enable = en;
    old = m_state;
    case (old)
      0: if (en) m_state = 1;
      1: if (!en) m_state = 2;
      default: begin
        if (en) m_state = 1;
        else if (mh == H_TOTAL - 1 && mv == V_TOTAL - 1) m_state = 0;
      end
    endcase
    if (old != 0) begin
      if (mh == H_TOTAL - 1) begin mh = 0; mv = nv; end
      else mh++;
    end
    @(posedge clk_pixel);
    @(negedge clk_pixel);
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (3) @(negedge clk_pixel);
    chk_reset("por");
    rst_n = 1'b1;
    repeat (4) cyc(1'b0);

    // Steady run; count pin activity over exactly one frame.
    repeat (100) cyc(1'b1);
    win = 1'b1;
    repeat (H_TOTAL * V_TOTAL) cyc(1'b1);
    win = 1'b0;
    chk("den_per_frame", den_cnt, 32);
    chk("hs_per_frame", hs_cnt, 2 * V_TOTAL);
    chk("vs_per_frame", vs_cnt, H_TOTAL);

    // Drop mid-frame, re-raise while draining: no discontinuity.
    repeat (40) cyc(1'b1);
    repeat (10) cyc(1'b0);
    repeat (60) cyc(1'b1);
    // Drop and hold: current frame completes, then idle.
    repeat (250) cyc(1'b0);
    chk("idle_after_drain", 32'(busy), 0);
    chk("idle_den", 32'(den), 0);

    // Async reset in the middle of an active line.
    repeat (30) cyc(1'b1);
    guard = 0;
    while (!m_de() && guard < 200) begin
      cyc(1'b1);
      guard++;
    end
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    @(negedge clk_pixel);
    @(negedge clk_pixel);
    enable = 1'b1;
    rst_n  = 1'b1;
    model_reset();
    first_wait = 1'b1;
    repeat (120) cyc(1'b1);
    chk("first_pulse_seen", 32'(first_seen), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
